mips_cpu_data_bridge: RTL and testbench

- Sits between the data port of mips_cpu_harvard and a word-organised synchronous RAM (1-cycle read latency).
- Converts CPU byte-enabled loads/stores into RAM word accesses; performs read-modify-write for partial stores (SB/SH/SWL/SWR).
- Stalls the CPU via waitrequest while a multi-cycle access is in flight.
- Decodes an address window and flags accesses outside it.

---
 rtl/mips_cpu_data_bridge_if.sv | 35 +++
 rtl/mips_cpu_data_bridge.sv | 145 ++++++++++++++
 tb/tb_mips_cpu_data_bridge.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_data_bridge_if.sv
// rtl/mips_cpu_data_bridge_if.sv - CPU data port and word RAM port bundle
interface mips_cpu_data_bridge_if #(
  parameter int ADDR_W = 10
);
  // CPU side
  logic [31:0]       cpu_address;
  logic              cpu_read;
  logic              cpu_write;
  logic [3:0]        cpu_byteenable;
  logic [31:0]       cpu_writedata;
  logic [31:0]       cpu_readdata;
  logic              cpu_waitrequest;
  // RAM side
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic [31:0]       mem_readdata;

  // Bridge view: consumes CPU requests and RAM read data
  modport slave (
    input  cpu_address, cpu_read, cpu_write, cpu_byteenable, cpu_writedata,
    output cpu_readdata, cpu_waitrequest,
    output mem_address, mem_read, mem_write, mem_writedata,
    input  mem_readdata
  );

  // Environment view: CPU issuing requests and RAM answering them
  modport master (
    output cpu_address, cpu_read, cpu_write, cpu_byteenable, cpu_writedata,
    input  cpu_readdata, cpu_waitrequest,
    input  mem_address, mem_read, mem_write, mem_writedata,
    output mem_readdata
  );
endinterface

// File: rtl/mips_cpu_data_bridge.sv
// rtl/mips_cpu_data_bridge.sv - byte-enabled CPU loads/stores onto a word RAM with RMW
module mips_cpu_data_bridge #(
  parameter int          ADDR_W = 10,
  parameter logic [31:0] BASE   = 32'h0000_0000
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clk_enable,
  mips_cpu_data_bridge_if.slave    io_bus,
  output logic                     o_bus_error
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD_RESP, S_RMW_WRITE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [31:0]       r_readdata;
  logic              r_bus_error;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_mask;

  // Window decode works on word addresses; the byte offset bits play no role.
  logic [29:0]       w_word_off;
  logic              w_hit;
  logic [ADDR_W-1:0] w_index;
  logic              w_unused_lsb;

  logic              w_mem_read;
  logic              w_mem_write;
  logic [ADDR_W-1:0] w_mem_address;
  logic [31:0]       w_mem_writedata;
  logic              w_waitrequest;
  logic              w_set_err;
  logic              w_load_miss;
  logic              w_latch_addr;
  logic              w_latch_store;
  logic [31:0]       w_merged;

  assign w_word_off   = io_bus.cpu_address[31:2] - BASE[31:2];
  assign w_hit        = (w_word_off[29:ADDR_W] == '0);
  assign w_index      = w_word_off[ADDR_W-1:0];
  assign w_unused_lsb = ^io_bus.cpu_address[1:0];

  // Merge latched store lanes over the word just read back from RAM
  always_comb begin
    w_merged = io_bus.mem_readdata;
    for (int n = 0; n < 4; n++) begin
      if (r_mask[n]) w_merged[8*n +: 8] = r_wdata[8*n +: 8];
    end
  end

  // Next-state, RAM strobes and CPU handshake
  always_comb begin
    w_next          = r_state;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_mem_address   = '0;
    w_mem_writedata = '0;
    w_waitrequest   = 1'b0;
    w_set_err       = 1'b0;
    w_load_miss     = 1'b0;
    w_latch_addr    = 1'b0;
    w_latch_store   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_bus.cpu_write) begin
          // A simultaneous read is illegal; the store still goes ahead.
          if (io_bus.cpu_read || !w_hit) w_set_err = 1'b1;
          if (w_hit && io_bus.cpu_byteenable == 4'b1111) begin
            w_mem_write     = 1'b1;
            w_mem_address   = w_index;
            w_mem_writedata = io_bus.cpu_writedata;
          end else if (w_hit && io_bus.cpu_byteenable != 4'b0000) begin
            w_mem_read    = 1'b1;
            w_mem_address = w_index;
            w_waitrequest = 1'b1;
            w_latch_addr  = 1'b1;
            w_latch_store = 1'b1;
            w_next        = S_RMW_WRITE;
          end
        end else if (io_bus.cpu_read) begin
          if (!w_hit) begin
            w_set_err   = 1'b1;
            w_load_miss = 1'b1;
          end else begin
            w_mem_read    = 1'b1;
            w_mem_address = w_index;
            w_waitrequest = 1'b1;
            w_latch_addr  = 1'b1;
            w_next        = S_LOAD_RESP;
          end
        end
      end
      S_LOAD_RESP: begin
        w_mem_address = r_addr;
        w_next        = S_IDLE;
      end
      S_RMW_WRITE: begin
        w_mem_write     = 1'b1;
        w_mem_address   = r_addr;
        w_mem_writedata = w_merged;
        w_next          = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Frozen cycle: no RAM activity, and an in-flight access keeps the CPU stalled.
    if (!i_clk_enable) begin
      w_mem_read    = 1'b0;
      w_mem_write   = 1'b0;
      w_waitrequest = (r_state != S_IDLE);
    end
  end

  // State register and latched request copies, frozen while clk_enable is low
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_readdata  <= '0;
      r_bus_error <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_mask      <= '0;
    end else if (i_clk_enable) begin
      r_state <= w_next;
      if (w_set_err) r_bus_error <= 1'b1;
      if (w_load_miss) r_readdata <= '0;
      else if (r_state == S_LOAD_RESP) r_readdata <= io_bus.mem_readdata;
      if (w_latch_addr) r_addr <= w_index;
      if (w_latch_store) begin
        r_wdata <= io_bus.cpu_writedata;
        r_mask  <= io_bus.cpu_byteenable;
      end
    end
  end

  assign io_bus.cpu_readdata    = r_readdata;
  assign io_bus.cpu_waitrequest = w_waitrequest;
  assign io_bus.mem_address     = w_mem_address;
  assign io_bus.mem_read        = w_mem_read;
  assign io_bus.mem_write       = w_mem_write;
  assign io_bus.mem_writedata   = w_mem_writedata;
  assign o_bus_error            = r_bus_error;

endmodule

// File: tb/tb_mips_cpu_data_bridge.sv
// tb/tb_mips_cpu_data_bridge.sv - randomized bench for mips_cpu_data_bridge
module tb_mips_cpu_data_bridge;
  localparam int          ADDR_W = 6;
  localparam int          DEPTH  = 1 << ADDR_W;
  localparam logic [31:0] BASE   = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst_n;
  logic clk_en;
  logic bus_error;

  int n_total = 0;
  int n_bad   = 0;

  mips_cpu_data_bridge_if #(.ADDR_W(ADDR_W)) bus ();

  mips_cpu_data_bridge #(.ADDR_W(ADDR_W), .BASE(BASE)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_clk_enable (clk_en),
    .io_bus       (bus.slave),
    .o_bus_error  (bus_error)
  );

  always #5 clk = ~clk;

  // Word RAM with one-cycle read latency, gated by the global enable
  logic [31:0] ram [0:DEPTH-1];
  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = 32'h0;
    bus.mem_readdata = 32'h0;
  end
  always @(posedge clk) begin
    if (clk_en) begin
      if (bus.mem_write) ram[bus.mem_address] <= bus.mem_writedata;
      if (bus.mem_read) bus.mem_readdata <= ram[bus.mem_address];
    end
  end

  // Reference model: byte-level memory image, sticky error, last load value
  logic [31:0] ref_mem [0:DEPTH-1];
  logic        ref_err;
  logic [31:0] ref_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.cpu_read       = 1'b0;
    bus.cpu_write      = 1'b0;
    bus.cpu_byteenable = 4'h0;
    bus.cpu_writedata  = 32'h0;
    bus.cpu_address    = 32'h0;
  endtask

  task automatic do_op(input string tag, input bit rd, input bit wr,
                       input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
    int          stalls, nrd, nwr, e_stall, e_rd, e_wr, idx;
    bit          done, hit;
    logic [31:0] lastw, merged;
    hit = (addr >= BASE) && (addr < BASE + 4 * DEPTH);
    idx = hit ? int'((addr - BASE) / 4) : 0;
    e_stall = 0; e_rd = 0; e_wr = 0; merged = 32'h0;
    if (wr) begin
      if (rd || !hit) ref_err = 1'b1;
      if (hit && be != 4'h0) begin
        merged = ref_mem[idx];
        for (int n = 0; n < 4; n++) if (be[n]) merged[8*n +: 8] = wd[8*n +: 8];
        ref_mem[idx] = merged;
        e_wr = 1;
        if (be != 4'hf) begin e_rd = 1; e_stall = 1; end
      end
    end else if (rd) begin
      if (hit) begin e_rd = 1; e_stall = 1; ref_rd = ref_mem[idx]; end
      else begin ref_err = 1'b1; ref_rd = 32'h0; end
    end

    @(negedge clk);
    bus.cpu_address = addr; bus.cpu_read = rd; bus.cpu_write = wr;
    bus.cpu_byteenable = be; bus.cpu_writedata = wd;
    #1;
    stalls = 0; nrd = 0; nwr = 0; lastw = 32'h0; done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      if (bus.mem_read) nrd++;
      if (bus.mem_write) begin nwr++; lastw = bus.mem_writedata; end
      if (!bus.cpu_waitrequest) done = 1'b1;
      else stalls++;
    end
    chk({tag, " accepted"}, 32'(done), 32'd1);
    @(posedge clk); #1;
    idle_inputs();
    chk({tag, " stall"}, stalls, e_stall);
    chk({tag, " rdstrobe"}, nrd, e_rd);
    chk({tag, " wrstrobe"}, nwr, e_wr);
    if (e_wr != 0) chk({tag, " wdata"}, lastw, merged);
    chk({tag, " err"}, 32'(bus_error), 32'(ref_err));
    chk({tag, " rdata"}, bus.cpu_readdata, ref_rd);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  m;
    int          op;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    ref_err = 1'b0; ref_rd = 32'h0;
    clk_en = 1'b1; rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("rst wait", 32'(bus.cpu_waitrequest), 32'd0);
    chk("rst rdata", bus.cpu_readdata, 32'h0);
    chk("rst err", 32'(bus_error), 32'd0);
    chk("rst mrd", 32'(bus.mem_read), 32'd0);
    chk("rst mwr", 32'(bus.mem_write), 32'd0);
    chk("rst maddr", 32'(bus.mem_address), 32'd0);
    chk("rst mwdata", bus.mem_writedata, 32'h0);

    do_op("sw", 0, 1, BASE + 32'h10, 4'hf, 32'h12345678);
    do_op("lw", 1, 0, BASE + 32'h10, 4'hf, 32'h0);
    do_op("sw2", 0, 1, BASE + 32'h20, 4'hf, 32'hAABBCCDD);
    do_op("sb", 0, 1, BASE + 32'h21, 4'b0010, 32'h0000EE00);
    do_op("lw2", 1, 0, BASE + 32'h20, 4'hf, 32'h0);
    do_op("sw3", 0, 1, BASE + 32'h24, 4'hf, 32'h11223344);
    do_op("sh", 0, 1, BASE + 32'h26, 4'b1100, 32'h55660000);
    do_op("s0", 0, 1, BASE + 32'h24, 4'b0000, 32'hFFFFFFFF);
    do_op("lw3", 1, 0, BASE + 32'h24, 4'hf, 32'h0);

    // Freeze the bridge for three cycles in the middle of a load response
    @(negedge clk);
    bus.cpu_address = BASE + 32'h20; bus.cpu_read = 1'b1; bus.cpu_byteenable = 4'hf;
    #1;
    chk("ce req wait", 32'(bus.cpu_waitrequest), 32'd1);
    @(posedge clk); #1;
    clk_en = 1'b0;
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("ce frozen wait", 32'(bus.cpu_waitrequest), 32'd1);
      chk("ce frozen strobe", 32'(bus.mem_read | bus.mem_write), 32'd0);
      @(posedge clk); #1;
    end
    clk_en = 1'b1;
    @(negedge clk);
    chk("ce resp wait", 32'(bus.cpu_waitrequest), 32'd0);
    @(posedge clk); #1;
    ref_rd = ref_mem[8];
    chk("ce rdata", bus.cpu_readdata, ref_rd);

    // Reset lands in the write half of a byte store; the word must survive
    do_op("sw4", 0, 1, BASE + 32'h30, 4'hf, 32'h11223344);
    @(negedge clk);
    bus.cpu_address = BASE + 32'h30; bus.cpu_write = 1'b1;
    bus.cpu_byteenable = 4'b0001; bus.cpu_writedata = 32'h000000FF;
    #1;
    chk("rmw rst req wait", 32'(bus.cpu_waitrequest), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    chk("rmw rst mwr", 32'(bus.mem_write), 32'd0);
    chk("rmw rst mrd", 32'(bus.mem_read), 32'd0);
    chk("rmw rst wait", 32'(bus.cpu_waitrequest), 32'd0);
    chk("rmw rst err", 32'(bus_error), 32'd0);
    chk("rmw rst rdata", bus.cpu_readdata, 32'h0);
    chk("rmw rst maddr", 32'(bus.mem_address), 32'd0);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    ref_err = 1'b0; ref_rd = 32'h0;
    do_op("rmw rst lw", 1, 0, BASE + 32'h30, 4'hf, 32'h0);

    do_op("miss lw", 1, 0, BASE + 4 * DEPTH, 4'hf, 32'h0);
    do_op("miss after lw", 1, 0, BASE + 32'h10, 4'hf, 32'h0);
    do_op("both rw", 1, 1, BASE + 32'h40, 4'hf, 32'hCAFEF00D);

    for (int t = 0; t < 200; t++) begin
      if ($urandom_range(0, 9) < 8) a = BASE + 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(0, 3));
      else if ($urandom_range(0, 1) == 0) a = BASE + 4 * DEPTH + 32'($urandom_range(0, 1023));
      else a = BASE - 1 - 32'($urandom_range(0, 255));
      m  = ($urandom_range(0, 3) == 0) ? 4'hf : 4'($urandom_range(0, 15));
      d  = $urandom;
      op = $urandom_range(0, 19);
      if (op < 8) do_op("rnd lw", 1, 0, a, 4'hf, 32'h0);
      else if (op < 19) do_op("rnd st", 0, 1, a, m, d);
      else do_op("rnd rw", 1, 1, a, m, d);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
